// File: rtl/bow_pkg.sv
// rtl/bow_pkg.sv - shared types, constants and helpers for the BoW receive link
package bow_pkg;

  localparam int BOW_WORD_W = 16;

  // bit n set means a lane width of n bits divides the word evenly into beats
  localparam logic [BOW_WORD_W:0] LANE_W_LEGAL = 17'h10116;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  function automatic int beats(input int lane_w);
    return BOW_WORD_W / lane_w;
  endfunction

endpackage

// File: rtl/bow_sync_fifo.sv
// rtl/bow_sync_fifo.sv - DEPTH-entry synchronous FIFO of {aux, fec, data} words
// peek_data exposes the entry behind the head so a reader can chain pops without a bubble.
module bow_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [W-1:0]           peek_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign peek_data = mem_q[rd_ptr_q + PTR_W'(1)];
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/bow_rx_link.sv
// rtl/bow_rx_link.sv - BoW receive link: beat assembly, word FIFO and APB write master
// Define BOW_RX_PARITY_EN to treat lane_fec as even parity and expose par_err_cnt.
module bow_rx_link #(
  parameter int LANE_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [LANE_W-1:0] lane_data,
  input  logic              lane_fec,
  input  logic              lane_aux,
  input  logic              lane_valid,
  input  logic              lane_sof,
  output logic              rx_ready,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [15:0]       pwdata,
  output logic              pfec,
  output logic              paux,
  input  logic              pready,
`ifdef BOW_RX_PARITY_EN
  output logic [7:0]        par_err_cnt,
`endif
  output logic              ovf_err
);
  import bow_pkg::*;

  localparam int BEATS = beats(LANE_W);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int FW    = BOW_WORD_W + 2;

  if (!LANE_W_LEGAL[LANE_W]) begin : g_bad_lane_w
    $error("bow_rx_link: LANE_W must be 1, 2, 4, 8 or 16");
  end

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BOW_WORD_W-1:0] asm_q, asm_d;
  logic                  fec_q, fec_d, aux_q, aux_d;
  logic                  word_done, push, push_ok, pop, more;
  logic [FW-1:0]         word, head, peek, nxt_word;
  logic                  full, empty;
  logic [OCC_W-1:0]      occ, occ_next;
  logic                  ovf_q, ovf_d, rx_ready_q, rx_ready_d;
  apb_state_e            state_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [FW-1:0]         pword_q;

  // cnt_q = 0 means no word is open; otherwise it is the index of the next slice
  always_comb begin
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    fec_d     = fec_q;
    aux_d     = aux_q;
    word_done = 1'b0;
    if (lane_valid && lane_sof) begin
      asm_d[LANE_W-1:0] = lane_data;
      fec_d             = lane_fec;
      aux_d             = lane_aux;
      cnt_d             = CNT_W'(1);
      if (BEATS == 1) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end
    end else if (lane_valid && cnt_q != '0) begin
      asm_d[int'(cnt_q) * LANE_W +: LANE_W] = lane_data;
      if (int'(cnt_q) == BEATS - 1) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    word = {aux_d, fec_d, asm_d};
  end

`ifdef BOW_RX_PARITY_EN
  logic       par_ok;
  logic [7:0] par_cnt_q, par_cnt_d;

  assign par_ok = ~^word[BOW_WORD_W:0];
  assign push   = word_done & par_ok;

  always_comb begin
    par_cnt_d = par_cnt_q;
    if (word_done && !par_ok && par_cnt_q != 8'hFF) begin
      par_cnt_d = par_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) par_cnt_q <= '0;
    else        par_cnt_q <= par_cnt_d;
  end

  assign par_err_cnt = par_cnt_q;
  assign pfec        = 1'b0;
`else
  assign push = word_done;
  assign pfec = pword_q[BOW_WORD_W];
`endif

  assign pop     = (state_q == APB_ACCESS) && pready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the word
  assign push_ok = push && (!full || pop);

  bow_sync_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk       (pclk),
    .rst       (preset),
    .wr_en     (push_ok),
    .wr_data   (word),
    .rd_en     (pop),
    .rd_data   (head),
    .peek_data (peek),
    .full      (full),
    .empty     (empty),
    .count     (occ)
  );

  always_comb begin
    ovf_d      = ovf_q | (push & full & ~pop);
    occ_next   = occ + OCC_W'(push_ok) - OCC_W'(pop);
    rx_ready_d = (occ_next <= OCC_W'(DEPTH - 2));
    more       = (occ > OCC_W'(1)) || push_ok;
    nxt_word   = (occ > OCC_W'(1)) ? peek : word;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      fec_q      <= 1'b0;
      aux_q      <= 1'b0;
      ovf_q      <= 1'b0;
      rx_ready_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      fec_q      <= fec_d;
      aux_q      <= aux_d;
      ovf_q      <= ovf_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= APB_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pword_q   <= '0;
    end else begin
      case (state_q)
        APB_IDLE: begin
          if (!empty) begin
            state_q  <= APB_SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= 1'b1;
            pword_q  <= head;
          end
        end
        APB_SETUP: begin
          state_q   <= APB_ACCESS;
          penable_q <= 1'b1;
        end
        APB_ACCESS: begin
          if (pready) begin
            penable_q <= 1'b0;
            if (more) begin
              state_q <= APB_SETUP;
              pword_q <= nxt_word;
            end else begin
              state_q  <= APB_IDLE;
              psel_q   <= 1'b0;
              pwrite_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= APB_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          pwrite_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign pwdata   = pword_q[BOW_WORD_W-1:0];
  assign paux     = pword_q[FW-1];
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_bow_rx_link.sv
// tb/tb_bow_rx_link.sv - self-checking bench for bow_rx_link (LANE_W=4, DEPTH=4)
// Honours BOW_RX_PARITY_EN when defined for the build.
module tb_bow_rx_link;

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  lane_data;
  logic        lane_fec, lane_aux, lane_valid, lane_sof;
  logic        rx_ready, psel, penable, pwrite, pfec, paux, pready, ovf_err;
  logic [15:0] pwdata;
`ifdef BOW_RX_PARITY_EN
  logic [7:0]  par_err_cnt;
  localparam bit PFEC = 1'b0;
`else
  localparam bit PFEC = 1'b1;
`endif

  bow_rx_link #(.LANE_W(4), .DEPTH(4)) dut (
    .pclk       (pclk),
    .preset     (preset),
    .lane_data  (lane_data),
    .lane_fec   (lane_fec),
    .lane_aux   (lane_aux),
    .lane_valid (lane_valid),
    .lane_sof   (lane_sof),
    .rx_ready   (rx_ready),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pfec       (pfec),
    .paux       (paux),
    .pready     (pready),
`ifdef BOW_RX_PARITY_EN
    .par_err_cnt(par_err_cnt),
`endif
    .ovf_err    (ovf_err)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];

  always @(negedge pclk) begin
    if (!preset && psel && penable && pready) got_q.push_back({paux, pfec, pwdata});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_lane();
    lane_valid = 1'b0;
    lane_sof   = 1'b0;
    lane_data  = '0;
    lane_fec   = 1'b0;
    lane_aux   = 1'b0;
  endtask

  // seq holds the beats in presentation order, first beat in the top nibble
  task automatic send_seq(input logic [15:0] seq, input logic f, input logic a, input int n);
    for (int i = 0; i < n; i++) begin
      lane_valid = 1'b1;
      lane_sof   = (i == 0);
      lane_data  = seq[(15 - 4*i) -: 4];
      lane_fec   = f;
      lane_aux   = a;
      step();
    end
    idle_lane();
  endtask

  task automatic send_word(input logic [15:0] w, input logic f, input logic a);
    send_seq({w[3:0], w[7:4], w[11:8], w[15:12]}, f, a, 4);
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, (got_q.size() >= n), 1);
  endtask

  task automatic wait_penable(input string name, input int budget);
    int k = 0;
    while (penable !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(name, penable, 1'b1);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    step();
    step();
    preset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] seq;
    logic        fec;
    logic        aux;
    logic [15:0] exp_data;
    logic        exp_fec;
    logic        exp_aux;
  } vec_t;
  vec_t vecs[6];

  // word-level reference for the random phase
  int          m_open, m_idx, m_par;
  logic [15:0] m_word;
  logic        m_fec, m_aux;

  task automatic model_beat(input logic v, input logic s, input logic [3:0] d,
                            input logic f, input logic a);
    if (v) begin
      if (s) begin
        m_open = 1; m_idx = 1; m_word = 16'(d); m_fec = f; m_aux = a;
      end else if (m_open != 0) begin
        m_word = m_word + (16'(d) << (4 * m_idx));
        m_idx++;
      end
      if (m_open != 0 && m_idx == 4) begin
        m_open = 0;
`ifdef BOW_RX_PARITY_EN
        if ((($countones(m_word) + int'(m_fec)) % 2) == 0) exp_q.push_back({m_aux, 1'b0, m_word});
        else if (m_par < 255) m_par++;
`else
        exp_q.push_back({m_aux, m_fec, m_word});
`endif
      end
    end
  endtask

  initial begin
    vecs[0] = '{16'h4321, 1'b1, 1'b0, 16'h1234, PFEC & 1'b1, 1'b0};
    vecs[1] = '{16'hFEEB, 1'b1, 1'b1, 16'hBEEF, PFEC & 1'b1, 1'b1};
    vecs[2] = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0,        1'b1};
    vecs[3] = '{16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0,        1'b0};
    vecs[4] = '{16'h1000, 1'b1, 1'b0, 16'h0001, PFEC & 1'b1, 1'b0};
    vecs[5] = '{16'h5A3C, 1'b0, 1'b1, 16'hC3A5, 1'b0,        1'b1};

    idle_lane();
    pready = 1'b0;
    do_reset();

    chk("reset rx_ready", rx_ready, 1'b1);
    chk("reset psel", psel, 1'b0);
    chk("reset penable", penable, 1'b0);
    chk("reset pwrite", pwrite, 1'b0);
    chk("reset pwdata", pwdata, 16'h0000);
    chk("reset pfec", pfec, 1'b0);
    chk("reset paux", paux, 1'b0);
    chk("reset ovf_err", ovf_err, 1'b0);
`ifdef BOW_RX_PARITY_EN
    chk("reset par_err_cnt", par_err_cnt, 8'd0);
`endif

    // latency: last beat in t, psel in t+2, penable in t+3
    pready = 1'b1;
    got_q.delete();
    send_word(16'h1234, 1'b1, 1'b0);
    chk("lat t+1 psel", psel, 1'b0);
    step();
    chk("lat t+2 psel", psel, 1'b1);
    chk("lat t+2 penable", penable, 1'b0);
    chk("lat t+2 pwrite", pwrite, 1'b1);
    chk("lat t+2 pwdata", pwdata, 16'h1234);
    chk("lat t+2 pfec", pfec, PFEC);
    chk("lat t+2 paux", paux, 1'b0);
    step();
    chk("lat t+3 penable", penable, 1'b1);
    chk("lat t+3 psel", psel, 1'b1);
    step();
    chk("lat t+4 idle psel", psel, 1'b0);
    chk("lat t+4 idle pwrite", pwrite, 1'b0);
    chk("lat write count", got_q.size(), 1);

    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      send_seq(vecs[i].seq, vecs[i].fec, vecs[i].aux, 4);
      wait_writes($sformatf("vec%0d write", i), 1, 20);
      repeat (3) step();
      chk($sformatf("vec%0d count", i), got_q.size(), 1);
      if (got_q.size() > 0)
        chk($sformatf("vec%0d word", i), got_q[0],
            {vecs[i].exp_aux, vecs[i].exp_fec, vecs[i].exp_data});
    end

    // pready low in ACCESS: outputs hold, no pop
    pready = 1'b0;
    got_q.delete();
    send_word(16'hA5C3, 1'b0, 1'b0);
    wait_penable("hold reach access", 10);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d psel", i), psel, 1'b1);
      chk($sformatf("hold%0d penable", i), penable, 1'b1);
      chk($sformatf("hold%0d pwdata", i), pwdata, 16'hA5C3);
      chk($sformatf("hold%0d no write", i), got_q.size(), 0);
      step();
    end
    pready = 1'b1;
    step();
    chk("hold release count", got_q.size(), 1);
    chk("hold release idle", psel, 1'b0);

    // overflow with pready low
    pready = 1'b0;
    got_q.delete();
    send_word(16'h1111, 1'b0, 1'b0);
    chk("ovf rx_ready after 1", rx_ready, 1'b1);
    send_word(16'h2222, 1'b0, 1'b0);
    chk("ovf rx_ready after 2", rx_ready, 1'b1);
    send_word(16'h3333, 1'b0, 1'b0);
    chk("ovf rx_ready after 3", rx_ready, 1'b0);
    send_word(16'h4444, 1'b0, 1'b0);
    chk("ovf not yet", ovf_err, 1'b0);
    send_word(16'h5555, 1'b0, 1'b0);
    chk("ovf set", ovf_err, 1'b1);
    pready = 1'b1;
    wait_writes("ovf drain", 4, 40);
    repeat (10) step();
    chk("ovf write count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("ovf order%0d", i), got_q[i], {2'b00, {4{4'(i + 1)}}});
    chk("ovf sticky", ovf_err, 1'b1);
    chk("ovf rx_ready back", rx_ready, 1'b1);

    // SOF restart drops the partial word
    got_q.delete();
    send_seq(16'h9876, 1'b0, 1'b1, 2);
    send_word(16'hBEEF, 1'b1, 1'b0);
    wait_writes("restart write", 1, 20);
    repeat (5) step();
    chk("restart count", got_q.size(), 1);
    if (got_q.size() > 0) chk("restart word", got_q[0], {1'b0, PFEC, 16'hBEEF});

    // reset during ACCESS with two words queued
    pready = 1'b0;
    got_q.delete();
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    wait_penable("rst reach access", 10);
    preset = 1'b1;
    step();
    chk("rst psel", psel, 1'b0);
    chk("rst penable", penable, 1'b0);
    chk("rst pwrite", pwrite, 1'b0);
    chk("rst pwdata", pwdata, 16'h0000);
    chk("rst pfec/paux", {pfec, paux}, 2'b00);
    chk("rst ovf_err", ovf_err, 1'b0);
    chk("rst rx_ready", rx_ready, 1'b1);
    preset = 1'b0;
    pready = 1'b1;
    repeat (10) step();
    chk("rst no writes", got_q.size(), 0);

`ifdef BOW_RX_PARITY_EN
    got_q.delete();
    send_word(16'h0001, 1'b0, 1'b0);
    repeat (6) step();
    chk("par bad dropped", got_q.size(), 0);
    chk("par cnt", par_err_cnt, 8'd1);
    send_word(16'h0001, 1'b1, 1'b0);
    wait_writes("par good write", 1, 20);
    if (got_q.size() > 0) chk("par good word", got_q[0], {2'b00, 16'h0001});
`endif

    // randomized traffic; the transmitter only opens a word while rx_ready is high
    do_reset();
    got_q.delete();
    exp_q.delete();
    m_open = 0; m_idx = 0; m_par = 0; m_word = '0; m_fec = 0; m_aux = 0;
    begin
      int tx_pos = 0;
      logic v, s, f, a;
      logic [3:0] d;
      for (int c = 0; c < 3000; c++) begin
        v = ($urandom_range(0, 3) != 0);
        s = 1'b0;
        d = 4'($urandom_range(0, 15));
        f = 1'($urandom_range(0, 1));
        a = 1'($urandom_range(0, 1));
        pready = 1'($urandom_range(0, 1));
        if (v) begin
          if (tx_pos == 0) begin
            if (rx_ready && $urandom_range(0, 4) != 0) begin
              s = 1'b1;
              tx_pos = 1;
            end
          end else if (rx_ready && $urandom_range(0, 11) == 0) begin
            s = 1'b1;
            tx_pos = 1;
          end else begin
            tx_pos++;
            if (tx_pos == 4) tx_pos = 0;
          end
        end
        lane_valid = v; lane_sof = s; lane_data = d; lane_fec = f; lane_aux = a;
        model_beat(v, s, d, f, a);
        step();
      end
    end
    idle_lane();
    pready = 1'b1;
    repeat (60) step();
    chk("rand write count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rand word%0d", i), got_q[i], exp_q[i]);
    chk("rand no overflow", ovf_err, 1'b0);
    chk("rand idle", psel, 1'b0);
`ifdef BOW_RX_PARITY_EN
    chk("rand par cnt", par_err_cnt, 8'(m_par));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
